// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding several byte producers into one UART transmitter
module uart_transmit #(
    parameter int DIVIDER = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       tx
);

    localparam int DW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIVIDER - 1);

    // frame = stop bit, data LSB first, start bit; bit 0 is always on the line
    logic [9:0]    shreg;
    logic [3:0]    bits_left;
    logic [DW-1:0] div_cnt;
    logic          active;

    // load a frame on send while idle, then shift one bit every DIVIDER clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '1;
            bits_left <= '0;
            div_cnt   <= '0;
            active    <= 1'b0;
        end else if (!active) begin
            if (send) begin
                shreg     <= {1'b1, data, 1'b0};
                bits_left <= 4'd10;
                div_cnt   <= '0;
                active    <= 1'b1;
            end
        end else if (div_cnt == DIV_MAX) begin
            div_cnt   <= '0;
            shreg     <= {1'b1, shreg[9:1]};
            bits_left <= bits_left - 4'd1;
            if (bits_left == 4'd1) begin
                active <= 1'b0;
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tx    = shreg[0];
    assign ready = !active;

endmodule

module uart_tx_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   ack,
    output logic [7:0]     tx_data,
    output logic           tx_send,
    input  logic           tx_ready,
    output logic [2:0]     grant_id,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] last;
    logic       grant_now;
    logic       win_found;
    int         win_idx;
    logic [7:0] win_data;

    // round-robin search starting just after the previous winner
    always_comb begin : winner_search
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!win_found && (|(req & (N'(1) << idx)))) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        win_data = 8'(req_data >> (8 * win_idx));
    end

    // next-state logic: grants happen only from IDLE with an idle transmitter
    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        case (state)
            IDLE: begin
                if (tx_ready && win_found) begin
                    grant_now = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!tx_ready) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (tx_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // registered grant outputs; send/ack are single-cycle because LAUNCH never grants
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_send  <= 1'b0;
            ack      <= '0;
            tx_data  <= 8'h00;
            grant_id <= 3'd0;
            last     <= 3'(N - 1);
        end else if (grant_now) begin
            tx_send  <= 1'b1;
            ack      <= N'(1) << win_idx;
            tx_data  <= win_data;
            grant_id <= 3'(win_idx);
            last     <= 3'(win_idx);
        end else begin
            tx_send  <= 1'b0;
            ack      <= '0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N, default 4, is the number of requesters sharing one uart_transmit; the legal range is 2..8.
REQ-002 Port clk, input, 1 bit: the single system clock; all logic is synchronous to its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port req, input, N bits: req[i]=1 means requester i has a byte pending.
REQ-005 Port req_data, input, 8*N bits: requester i's byte is on bits [8*i+7:8*i].
REQ-006 Port ack, output, N bits: a one-cycle pulse on ack[i] means requester i's byte was taken.
REQ-007 Port tx_data, output, 8 bits: byte to the transmitter data input.
REQ-008 Port tx_send, output, 1 bit: one-cycle start pulse to the transmitter send input.
REQ-009 Port tx_ready, input, 1 bit: transmitter ready; 1 means the transmitter is idle.
REQ-010 Port grant_id, output, 3 bits: index of the requester most recently granted.
REQ-011 Port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement a state machine with three states: IDLE, LAUNCH and DRAIN.
REQ-013 IDLE: when tx_ready=1 and req!=0, the block SHALL select a winner w by round-robin and move to LAUNCH on the same clock edge.
REQ-014 That same edge SHALL register tx_data=req_data[w], tx_send=1, ack[w]=1 and grant_id=w; the latency from a request sampled to tx_send/ack is exactly 1 cycle.
REQ-015 tx_send and ack SHALL each be high for exactly one cycle per grant; at most one ack bit is ever high.
REQ-016 LAUNCH: wait for tx_ready=0 (transmitter accepted the byte), then go to DRAIN; no new grant is made in LAUNCH.
REQ-017 DRAIN: wait for tx_ready=1, then go to IDLE; no new grant is made in DRAIN.
REQ-018 The earliest next grant SHALL occur on the edge after DRAIN->IDLE, provided req!=0 and tx_ready=1 at that time.
REQ-019 Round-robin order: search indices last+1, last+2, ... modulo N; the first index with req set wins.
REQ-020 last SHALL update to w on every grant.
REQ-021 A requester SHALL hold req[i] and its byte stable until it sees ack[i].
REQ-022 If req[i] is still 1 in the cycle after ack[i], it SHALL be treated as a new request; this allows back-to-back bytes from one requester.
REQ-023 Deasserting req[i] before ack[i] withdraws the request with no side effect.
REQ-024 In IDLE with tx_ready=0, no grant SHALL be made regardless of req.
REQ-025 If tx_ready is already low at LAUNCH entry, the block SHALL move to DRAIN after one cycle in LAUNCH.
REQ-026 tx_data SHALL hold its value until the next grant.
REQ-027 Only req bits [N-1:0] are examined; grant_id SHALL never exceed N-1.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, tx_send=0, ack=0, tx_data=8'h00, grant_id=0, busy=0, last=N-1 (so index 0 has highest priority first).
REQ-029 Reset asserted mid-transfer SHALL abandon the grant with no further ack or tx_send pulse.
REQ-030 After reset deasserts, the first grant follows REQ-013.
REQ-031 Reset SHALL take priority over all other inputs.

Verification
REQ-032 Single request: after reset, req=4'b0100 with byte 8'h41 on slot 2 and tx_ready=1 -> next cycle tx_send=1, tx_data=8'h41, ack=4'b0100, grant_id=2, busy=1.
REQ-033 Fairness: req=4'b1111 held, with the transmitter model dropping ready for 10 cycles after each send -> grant order 0,1,2,3,0; no requester is granted twice while others wait.
REQ-034 Handshake: tx_ready stays 1 for 3 cycles after tx_send before dropping -> state remains LAUNCH, no second tx_send, then DRAIN, then IDLE once ready returns.
REQ-035 Blocked start: tx_ready=0 in IDLE with req=4'b0001 -> no ack and no tx_send until tx_ready=1, then a grant within 1 cycle.
REQ-036 Reset mid-operation: reset during DRAIN -> all outputs at reset values next cycle; with req=4'b1000 and tx_ready=1 the next grant is 3, since last=N-1 makes index 0 top priority and index 0 is not requesting.
REQ-037 Loopback: drive a real uart_transmit with DIVIDER=868 and send bytes 8'h55 from slot 0 and 8'hAA from slot 1 simultaneously -> the serial line carries 8'h55 then 8'hAA with no corruption.
